// File: rtl/serial_sort_pkg.sv
// Shared types and sizing helpers for the serial sort stage.
// Also used by sort_cmp_swap and serial_sort_stage.
package serial_sort_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SORT = 3'd2,
        OUT  = 3'd3,
        DONE = 3'd4
    } state_e;

    localparam int DEF_DATA_W    = 4;
    localparam int DEF_NUM_WORDS = 8;

    // Bits needed to hold any value in 0..max_val (never less than one).
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// Combinational compare-exchange of two unsigned words.
// When desc_i=0, first_o gets the smaller word. Equal words never swap.
module sort_cmp_swap
    import serial_sort_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              desc_i,
    output logic [DATA_W-1:0] first_o,
    output logic [DATA_W-1:0] second_o
);

    logic swap;

    assign swap     = desc_i ? (a_i < b_i) : (a_i > b_i);
    assign first_o  = swap ? b_i : a_i;
    assign second_o = swap ? a_i : b_i;

endmodule

// File: rtl/serial_sort_stage.sv
// Bit-serial frame sorter: load, odd-even transposition sort, then serial output.
// Optional SORT_PARITY_EN appends an even-parity bit after every output word.
module serial_sort_stage
    import serial_sort_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_WORDS = DEF_NUM_WORDS
) (
    input  logic t_clk,
    input  logic rst,
    input  logic f_layer,
    input  logic sort_dir,
    input  logic data_in,
    input  logic in_valid,
    output logic data_out,
    output logic out_valid,
    output logic sort_finish,
    output logic busy
);

    localparam int TOTAL_BITS = NUM_WORDS * DATA_W;
`ifdef SORT_PARITY_EN
    localparam int OUT_BITS   = NUM_WORDS * (DATA_W + 1);
    localparam int BIT_W      = cnt_width(DATA_W);
    localparam logic [BIT_W-1:0] PAR_SLOT = BIT_W'(DATA_W);
`else
    localparam int OUT_BITS   = TOTAL_BITS;
`endif
    localparam int HALF       = NUM_WORDS / 2;
    localparam int CNT_W      = cnt_width(OUT_BITS);
    localparam int PASS_W     = cnt_width(NUM_WORDS - 1);

    localparam logic [CNT_W-1:0]  LOAD_LAST = CNT_W'(TOTAL_BITS);
    localparam logic [CNT_W-1:0]  OUT_LAST  = CNT_W'(OUT_BITS - 1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_WORDS - 1);

    state_e                 state_q, state_d;
    logic [TOTAL_BITS-1:0]  frame_q, frame_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic [PASS_W-1:0]      pass_q,  pass_d;
    logic                   dir_q,   dir_d;
`ifdef SORT_PARITY_EN
    logic [BIT_W-1:0]       bit_q,   bit_d;
    logic                   par_q,   par_d;
`endif

    logic [DATA_W-1:0]      word_w   [NUM_WORDS];
    logic [DATA_W-1:0]      sorted_w [NUM_WORDS];
    logic [DATA_W-1:0]      cmp_a    [HALF];
    logic [DATA_W-1:0]      cmp_b    [HALF];
    logic [DATA_W-1:0]      cmp_x    [HALF];
    logic [DATA_W-1:0]      cmp_y    [HALF];
    logic [TOTAL_BITS-1:0]  seed_flat;
    logic [TOTAL_BITS-1:0]  sorted_flat;
    logic                   odd_pass;
    logic                   out_bit;

    assign odd_pass = pass_q[0];

    // Word 0 occupies the top of the frame so it is shifted in and out first.
    always_comb begin
        seed_flat = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            word_w[i] = frame_q[TOTAL_BITS-1-i*DATA_W -: DATA_W];
            seed_flat[TOTAL_BITS-1-i*DATA_W -: DATA_W] = DATA_W'(NUM_WORDS - 1 - i);
        end
    end

    // On odd passes the last comparator's wrap-around pair is computed but discarded.
    for (genvar j = 0; j < HALF; j++) begin : g_cmp
        localparam int EA = 2 * j;
        localparam int EB = 2 * j + 1;
        localparam int OA = 2 * j + 1;
        localparam int OB = (2 * j + 2) % NUM_WORDS;

        assign cmp_a[j] = odd_pass ? word_w[OA] : word_w[EA];
        assign cmp_b[j] = odd_pass ? word_w[OB] : word_w[EB];

        sort_cmp_swap #(
            .DATA_W (DATA_W)
        ) u_cmp (
            .a_i      (cmp_a[j]),
            .b_i      (cmp_b[j]),
            .desc_i   (dir_q),
            .first_o  (cmp_x[j]),
            .second_o (cmp_y[j])
        );
    end

    always_comb begin
        for (int i = 0; i < NUM_WORDS; i++) begin
            sorted_w[i] = word_w[i];
        end
        for (int j = 0; j < HALF; j++) begin
            if (!odd_pass) begin
                sorted_w[2*j]   = cmp_x[j];
                sorted_w[2*j+1] = cmp_y[j];
            end else if (j < HALF - 1) begin
                sorted_w[2*j+1]               = cmp_x[j];
                sorted_w[(2*j+2) % NUM_WORDS] = cmp_y[j];
            end
        end
        sorted_flat = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            sorted_flat[TOTAL_BITS-1-i*DATA_W -: DATA_W] = sorted_w[i];
        end
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        dir_d   = dir_q;
        out_bit = 1'b0;
`ifdef SORT_PARITY_EN
        bit_d   = bit_q;
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (f_layer) begin
                    frame_d = seed_flat;
                    dir_d   = sort_dir;
                    pass_d  = '0;
                    cnt_d   = '0;
                    state_d = SORT;
                end else if (in_valid) begin
                    frame_d = {frame_q[TOTAL_BITS-2:0], data_in};
                    cnt_d   = CNT_W'(1);
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (cnt_q == LOAD_LAST) begin
                    dir_d   = sort_dir;
                    pass_d  = '0;
                    cnt_d   = '0;
                    state_d = SORT;
                end else if (in_valid) begin
                    frame_d = {frame_q[TOTAL_BITS-2:0], data_in};
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            SORT: begin
                frame_d = sorted_flat;
                if (pass_q == PASS_LAST) begin
                    pass_d  = '0;
                    cnt_d   = '0;
                    state_d = OUT;
                end else begin
                    pass_d  = pass_q + PASS_W'(1);
                end
            end
            OUT: begin
`ifdef SORT_PARITY_EN
                if (bit_q == PAR_SLOT) begin
                    out_bit = par_q;
                    par_d   = 1'b0;
                    bit_d   = '0;
                end else begin
                    out_bit = frame_q[TOTAL_BITS-1];
                    frame_d = {frame_q[TOTAL_BITS-2:0], 1'b0};
                    par_d   = par_q ^ frame_q[TOTAL_BITS-1];
                    bit_d   = bit_q + BIT_W'(1);
                end
`else
                out_bit = frame_q[TOTAL_BITS-1];
                frame_d = {frame_q[TOTAL_BITS-2:0], 1'b0};
`endif
                if (cnt_q == OUT_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge t_clk) begin
        if (rst) begin
            state_q <= IDLE;
            frame_q <= '0;
            cnt_q   <= '0;
            pass_q  <= '0;
            dir_q   <= 1'b0;
`ifdef SORT_PARITY_EN
            bit_q   <= '0;
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            dir_q   <= dir_d;
`ifdef SORT_PARITY_EN
            bit_q   <= bit_d;
            par_q   <= par_d;
`endif
        end
    end

    assign out_valid   = (state_q == OUT);
    assign data_out    = out_valid & out_bit;
    assign sort_finish = (state_q == DONE);
    assign busy        = (state_q != IDLE);

endmodule

// File: doc/serial_sort_stage.md
SERIAL_SORT_STAGE -- requirements
Module: serial_sort_stage

Interface
REQ-001 The parameter DATA_W SHALL default to 4 and set the width of one word in bits (legal range 2..16).
REQ-002 The parameter NUM_WORDS SHALL default to 8 and set the words per frame (even, legal range 2..32).
REQ-003 The port t_clk SHALL be an input, 1 bit: the single clock; all logic SHALL be rising-edge.
REQ-004 The port rst SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-005 The port f_layer SHALL be an input, 1 bit: 1 = first layer of the stack, which loads the internal seed pattern instead of serial input.
REQ-006 The port sort_dir SHALL be an input, 1 bit: 0 = ascending, 1 = descending.
REQ-007 The port data_in SHALL be an input, 1 bit: serial frame data, MSB of word 0 first.
REQ-008 The port in_valid SHALL be an input, 1 bit: data_in is valid on this edge.
REQ-009 The port data_out SHALL be an output, 1 bit: serial sorted data, MSB of word 0 first.
REQ-010 The port out_valid SHALL be an output, 1 bit: data_out is valid on this cycle.
REQ-011 The port sort_finish SHALL be an output, 1 bit: one-cycle pulse at the end of a frame.
REQ-012 The port busy SHALL be an output, 1 bit: high in every state except IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, LOAD, SORT, OUT and DONE.
REQ-014 In IDLE, f_layer=1 SHALL load word i = (NUM_WORDS-1-i) mod 2^DATA_W into every slot in one cycle and go to SORT; f_layer has priority over in_valid.
REQ-015 In IDLE with f_layer=0 and in_valid=1, the FSM SHALL capture data_in as bit 1 of the frame and go to LOAD.
REQ-016 LOAD SHALL capture one bit per edge with in_valid=1; cycles with in_valid=0 are gaps that change nothing; after bit NUM_WORDS*DATA_W the FSM SHALL go to SORT on the next edge.
REQ-017 in_valid and data_in SHALL be ignored in SORT, OUT and DONE.
REQ-018 sort_dir SHALL be registered on entry to SORT and held constant for the rest of the frame.
REQ-019 SORT SHALL run an odd-even transposition sort for exactly NUM_WORDS cycles:
- pass k even: compare-exchange pairs (0,1),(2,3),...
- pass k odd: compare-exchange pairs (1,2),(3,4),...
REQ-020 The compare SHALL be unsigned; equal words SHALL NOT swap.
REQ-021 OUT SHALL drive out_valid=1 for NUM_WORDS*DATA_W consecutive cycles with no gaps, word 0 first and MSB first, starting the cycle after the last SORT cycle.
REQ-022 DONE SHALL last one cycle with sort_finish=1, out_valid=0 and busy=1, then return to IDLE.
REQ-023 Frame latency (f_layer=0, no gaps) SHALL be: last input bit edge -> first out_valid = NUM_WORDS+1 cycles.
REQ-024 data_out SHALL be 0 whenever out_valid=0.

Reset
REQ-025 rst=1 on any edge, in any state (including mid-LOAD, mid-SORT and mid-OUT), SHALL force:
- IDLE, with the partial frame discarded;
- data_out=0, out_valid=0, sort_finish=0, busy=0;
- all word registers, bit counters and the pass counter cleared to 0.
REQ-026 The first edge after rst deasserts SHALL already be able to accept f_layer or in_valid.

Configuration
REQ-027 With the macro SORT_PARITY_EN defined, OUT SHALL append one even-parity bit (XOR of the word's bits) after each word, giving NUM_WORDS*(DATA_W+1) out_valid cycles.
REQ-028 Without SORT_PARITY_EN, no parity logic SHALL exist and OUT SHALL last exactly NUM_WORDS*DATA_W cycles.

Structure
REQ-029 The package serial_sort_pkg SHALL hold:
- the state enum (IDLE, LOAD, SORT, OUT, DONE);
- the default DATA_W and NUM_WORDS constants;
- the function that computes the counter widths.
REQ-030 The design SHALL contain one sub-module, sort_cmp_swap, a combinational compare-exchange of two DATA_W words controlled by the direction; it SHALL be instantiated NUM_WORDS/2 times, with the pairing muxed by pass parity.

Verification
REQ-031 Scenario: f_layer=0, ascending, words 0,1,2,2,4,5,5,5 -> same sequence out; sort_finish exactly 9+32 cycles after the last input bit.
REQ-032 Scenario: descending, words C,D,E,F,C,D,E,F -> F,F,E,E,D,D,C,C; then ascending words E,D,E,1,8,7,A,F -> 1,7,8,A,D,E,E,F.
REQ-033 Scenario: f_layer=1, ascending -> seed 7..0 sorted to 0,1,...,7; busy high from the first edge until one cycle after sort_finish.
REQ-034 Scenario: rst pulsed after 10 input bits -> all outputs 0 next cycle, then a fresh frame 3,3,3,3,0,0,0,0 -> 0,0,0,0,3,3,3,3.
REQ-035 Scenario: in_valid=0 gaps of 1-3 cycles inserted randomly -> output identical to the gap-free run.
REQ-036 Scenario: SORT_PARITY_EN defined, word E -> bits 1,1,1,0 then parity 1; word 0 -> 0,0,0,0 then 0; 40 out_valid cycles in total.
